burst_line_adapter: RTL
=======================

// Module: burst_line_adapter
// PURPOSE
// - Upstream stage of the burst RAM (simulation emulator or PSRAM IP). Converts one cache-line
//   request (read or write of BurstDataCount words) into exactly one RAM burst command.
// - Serialises write lines into per-beat words and gathers read beats back into one line.
// - Returns a single-cycle completion pulse. One request outstanding at a time.
// PARAMETERS
// - AddressBitWidth  4   RAM word address width (must match RAM)
// - DataBitWidth     64  RAM word width, bits
// - BurstDataCount   4   words per burst, power of 2, >=2 (must match RAM)
// - derived: LineBitWidth = DataBitWidth*BurstDataCount; BeatBits = $clog2(BurstDataCount);
//   LineAddrBitWidth = AddressBitWidth-BeatBits
// PORTS
// - clk               in   1                 clock, all logic on rising edge
// - rst_n             in   1                 asynchronous active-low reset
// - req_valid         in   1                 request present
// - req_ready         out  1                 adapter can accept (req taken when valid&ready)
// - req_write         in   1                 0: read line, 1: write line
// - req_line_addr     in   LineAddrBitWidth  line address
// - req_wr_line       in   LineBitWidth      write data; word i = bits [i*DataBitWidth +: DataBitWidth]
// - resp_valid        out  1                 one-cycle completion pulse
// - resp_write        out  1                 type of completed request
// - resp_rd_line      out  LineBitWidth      read line, valid when resp_valid & !resp_write
// - ram_cmd           out  1                 to RAM: 0 read, 1 write
// - ram_cmd_en        out  1                 to RAM: command strobe
// - ram_addr          out  AddressBitWidth   to RAM: {line_addr, BeatBits'b0}
// - ram_wr_data       out  DataBitWidth      to RAM: current write beat
// - ram_data_mask     out  DataBitWidth/8    to RAM: tied 0
// - ram_rd_data       in   DataBitWidth      from RAM: read beat
// - ram_rd_data_valid in   1                 from RAM: read beat valid
// - ram_init_calib    in   1                 from RAM: calibration done
// - ram_busy          in   1                 from RAM: busy
// BEHAVIOUR
// - Reset (async, rst_n=0): state=WAIT_CALIB, beat counter=0, resp_valid=0, resp_write=0,
//   resp_rd_line=0, latched line/addr/write=0; ram_cmd_en=0, req_ready=0. Reset mid-burst
//   abandons the request with no resp_valid; the RAM shares rst_n and is reset too.
// - FSM: WAIT_CALIB -> IDLE when ram_init_calib=1.
//   IDLE: req_ready=1. On req_valid: latch addr, line, write flag -> ISSUE.
//   ISSUE: ram_cmd_en = !ram_busy (only combinational path from a ram_* input). Hold ISSUE
//   while ram_busy=1. When issued: write -> WRITE_BEATS with beat=1; read -> READ_WAIT with beat=0.
//   WRITE_BEATS: ram_wr_data = word[beat], beat++ each cycle. After beat BurstDataCount-1 -> DONE.
//   READ_WAIT: each cycle with ram_rd_data_valid=1, store ram_rd_data into word[beat] and
//   increment beat. After BurstDataCount beats are captured -> DONE.
//   DONE: resp_valid=1 for exactly one cycle, resp_write=latched flag -> IDLE.
// - req_ready, ram_cmd, ram_addr and ram_wr_data are decoded from registered state only.
//   ram_cmd and ram_addr stay stable from ISSUE until DONE. ram_cmd_en=0 outside ISSUE.
// - In ISSUE, ram_wr_data = word0. The RAM writes word0 in the ISSUE cycle and words
//   1..BurstDataCount-1 on the following consecutive cycles. No gaps are allowed.
// - resp_rd_line holds its value until the next read completes. resp_rd_line is unchanged by writes.
// - ram_rd_data_valid outside READ_WAIT is ignored. Beats beyond BurstDataCount are ignored.
// - Beat counter is BeatBits wide and wraps to 0 on entry to DONE.
// - With RAM read delay 6 and 4 beats: read resp_valid arrives 12 cycles after the accept cycle.
//   Write resp_valid arrives 5 cycles after the accept cycle. Minimum spacing between accepts is
//   6 cycles for writes.
// TESTING
// - Reset then ram_init_calib low for 10 cycles -> req_ready=0 throughout. req_ready=1 on
//   the cycle after calib is seen.
// - Write line 0xDDDD..,0xCCCC..,0xBBBB..,0xAAAA.. to line addr 2 -> one ram_cmd_en, ram_addr=8,
//   words 0..3 on 4 consecutive cycles, then a single resp_valid with resp_write=1.
// - Read line addr 2 after that write -> resp_rd_line equals the written line, resp_valid=1
//   12 cycles after accept, ram_cmd_en high exactly 1 cycle.
// - Request while ram_busy=1 (back-to-back write then read) -> ISSUE holds with ram_cmd_en=0
//   until busy drops. Correct read data follows.
// - Spurious ram_rd_data_valid in IDLE, plus req_valid held during a busy burst -> no capture
//   and no second accept before DONE.
// - rst_n pulsed low in the middle of READ_WAIT -> all outputs at reset values immediately,
//   no resp_valid. A later read returns correct data.

Source files
------------

// File: rtl/burst_line_adapter.sv
// burst_line_adapter: converts one cache-line request into a single RAM burst,
// serialising write lines into beats and gathering read beats back into a line.
module burst_line_adapter #(
    parameter int AddressBitWidth = 4,
    parameter int DataBitWidth = 64,
    parameter int BurstDataCount = 4,
    localparam int LineBitWidth = DataBitWidth * BurstDataCount,
    localparam int BeatBits = $clog2(BurstDataCount),
    localparam int LineAddrBitWidth = AddressBitWidth - BeatBits
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_write,
    input  logic [LineAddrBitWidth-1:0] req_line_addr,
    input  logic [LineBitWidth-1:0]     req_wr_line,
    output logic                        resp_valid,
    output logic                        resp_write,
    output logic [LineBitWidth-1:0]     resp_rd_line,
    output logic                        ram_cmd,
    output logic                        ram_cmd_en,
    output logic [AddressBitWidth-1:0]  ram_addr,
    output logic [DataBitWidth-1:0]     ram_wr_data,
    output logic [DataBitWidth/8-1:0]   ram_data_mask,
    input  logic [DataBitWidth-1:0]     ram_rd_data,
    input  logic                        ram_rd_data_valid,
    input  logic                        ram_init_calib,
    input  logic                        ram_busy
);
    localparam logic [2:0] WAIT_CALIB  = 3'd0;
    localparam logic [2:0] IDLE        = 3'd1;
    localparam logic [2:0] ISSUE       = 3'd2;
    localparam logic [2:0] WRITE_BEATS = 3'd3;
    localparam logic [2:0] READ_WAIT   = 3'd4;
    localparam logic [2:0] DONE        = 3'd5;
    localparam logic [BeatBits-1:0] LAST_BEAT = BeatBits'(BurstDataCount - 1);

    logic [2:0]                  state_q, state_d;
    logic [BeatBits-1:0]         beat_q, beat_d;
    logic [LineBitWidth-1:0]     line_q, line_d, rd_line_q, rd_line_d;
    logic [LineAddrBitWidth-1:0] addr_q, addr_d;
    logic                        write_q, write_d;

    always_comb begin
        state_d = state_q;
        beat_d = beat_q;
        line_d = line_q;
        rd_line_d = rd_line_q;
        addr_d = addr_q;
        write_d = write_q;
        case (state_q)
            WAIT_CALIB: state_d = ram_init_calib ? IDLE : WAIT_CALIB;
            IDLE: if (req_valid) begin
                state_d = ISSUE;
                addr_d = req_line_addr;
                line_d = req_wr_line;
                write_d = req_write;
            end
            // word0 goes out with the command, so a write continues from beat 1
            ISSUE: if (!ram_busy) begin
                state_d = write_q ? WRITE_BEATS : READ_WAIT;
                beat_d = write_q ? BeatBits'(1) : '0;
            end
            WRITE_BEATS: begin
                beat_d = beat_q + BeatBits'(1);
                state_d = (beat_q == LAST_BEAT) ? DONE : WRITE_BEATS;
            end
            READ_WAIT: if (ram_rd_data_valid) begin
                line_d[int'(beat_q)*DataBitWidth +: DataBitWidth] = ram_rd_data;
                beat_d = beat_q + BeatBits'(1);
                if (beat_q == LAST_BEAT) begin
                    state_d = DONE;
                    rd_line_d = line_d;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = WAIT_CALIB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_CALIB;
            beat_q <= '0;
            line_q <= '0;
            rd_line_q <= '0;
            addr_q <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q <= beat_d;
            line_q <= line_d;
            rd_line_q <= rd_line_d;
            addr_q <= addr_d;
            write_q <= write_d;
        end
    end

    assign req_ready = state_q == IDLE;
    assign ram_cmd_en = (state_q == ISSUE) && !ram_busy;
    assign ram_cmd = write_q;
    assign ram_addr = {addr_q, {BeatBits{1'b0}}};
    assign ram_wr_data = line_q[int'(beat_q)*DataBitWidth +: DataBitWidth];
    assign ram_data_mask = '0;
    assign resp_valid = state_q == DONE;
    assign resp_write = write_q;
    assign resp_rd_line = rd_line_q;
endmodule
